// File: rtl/i2s_tx_multi.sv
// I2S transmitter: clk-derived sclk/lrclk, N_LINES stereo pairs, one-entry pending buffer, underrun flag.
// Latency: an accepted sample's left MSB reaches sd at the next frame load (at most 1 frame + 1 bclk later).
// Backpressure: sample_ready drops after a write and returns after that sample loads.
// UNDERRUN_HOLD_EN: when defined, an underrun repeats the last frame instead of sending silence.
module i2s_tx_multi #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 24,
  parameter int BCLK_DIV  = 4,
  parameter int N_LINES   = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic [N_LINES*2*WIDTH-1:0]   sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         underrun_clr,
  output logic                         sclk,
  output logic                         lrclk,
  output logic [N_LINES-1:0]           sd,
  output logic                         frame_tick,
  output logic                         underrun
);

  localparam int DW     = $clog2(BCLK_DIV + 1);
  localparam int BW     = $clog2(2 * SLOT_BITS + 1);
  localparam int DATA_W = N_LINES * 2 * WIDTH;

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_BITS);

  logic [DW-1:0]      div_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [DATA_W-1:0]  pending;
  logic               pending_full;
  logic [DATA_W-1:0]  active;

  logic               div_last;
  logic               fall_evt;
  logic               load_evt;
  logic               write_evt;
  logic [BW-1:0]      bit_nxt;
  logic               lrclk_nxt;
  logic [DATA_W-1:0]  active_nxt;
  logic               pending_full_nxt;
  logic [N_LINES-1:0] sd_nxt;
  int                 sd_k;
  int                 sd_ch;
  int                 sd_j;

  always_comb begin
    div_last  = (div_cnt == DIV_LAST);
    fall_evt  = enable && div_last && sclk;
    load_evt  = fall_evt && (bit_cnt == '0);
    write_evt = sample_valid && sample_ready;
    bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
    lrclk_nxt = (bit_nxt >= SLOT_B);
  end

  always_comb begin
    active_nxt = active;
    if (load_evt) begin
      if (pending_full) begin
        active_nxt = pending;
      end else begin
`ifdef UNDERRUN_HOLD_EN
        active_nxt = active;
`else
        active_nxt = '0;
`endif
      end
    end
  end

  // A write landing in the load cycle is kept for the following frame.
  always_comb begin
    pending_full_nxt = pending_full;
    if (write_evt) begin
      pending_full_nxt = 1'b1;
    end else if (load_evt) begin
      pending_full_nxt = 1'b0;
    end
  end

  // One-bit I2S delay: bit position b carries frame bit (b-1) mod frame length.
  always_comb begin
    sd_k  = (bit_nxt == '0) ? (2 * SLOT_BITS - 1) : (int'(bit_nxt) - 1);
    sd_ch = (sd_k >= SLOT_BITS) ? 1 : 0;
    sd_j  = sd_k - sd_ch * SLOT_BITS;
    sd_nxt = '0;
    for (int l = 0; l < N_LINES; l++) begin
      if (sd_j < WIDTH) begin
        sd_nxt[l] = active_nxt[(2 * l + sd_ch) * WIDTH + WIDTH - 1 - sd_j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sclk         <= 1'b0;
      lrclk        <= 1'b0;
      sd           <= '0;
      frame_tick   <= 1'b0;
      underrun     <= 1'b0;
      sample_ready <= 1'b0;
      pending      <= '0;
      pending_full <= 1'b0;
      active       <= '0;
    end else begin
      frame_tick   <= load_evt;
      active       <= active_nxt;
      pending_full <= pending_full_nxt;
      sample_ready <= !pending_full_nxt;
      if (write_evt) begin
        pending <= sample_data;
      end

      if (load_evt && !pending_full) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end

      if (!enable) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
        lrclk   <= 1'b0;
        sd      <= '0;
      end else begin
        if (div_last) begin
          div_cnt <= '0;
          sclk    <= !sclk;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        if (fall_evt) begin
          bit_cnt <= bit_nxt;
          lrclk   <= lrclk_nxt;
          sd      <= sd_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Bench for i2s_tx_multi: random samples, a behavioural I2S receiver on sclk rises, and a frame scoreboard.
module tb_i2s_tx_multi;

  localparam int WIDTH     = 24;
  localparam int SLOT_BITS = 28;
  localparam int BCLK_DIV  = 4;
  localparam int N_LINES   = 2;
  localparam int DW        = N_LINES * 2 * WIDTH;
  localparam int FRAME_CLK = 4 * SLOT_BITS * BCLK_DIV;

  logic               clk = 1'b0;
  logic               rstn;
  logic               enable;
  logic [DW-1:0]      sample_data;
  logic               sample_valid;
  logic               sample_ready;
  logic               underrun_clr;
  logic               sclk;
  logic               lrclk;
  logic [N_LINES-1:0] sd;
  logic               frame_tick;
  logic               underrun;

  i2s_tx_multi #(
    .WIDTH(WIDTH), .SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV), .N_LINES(N_LINES)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .underrun_clr(underrun_clr),
    .sclk(sclk), .lrclk(lrclk), .sd(sd), .frame_tick(frame_tick), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at the last rising edge.
  bit            hs_e, clr_e, en_e, rst_e;
  logic [DW-1:0] hs_d;
  always @(posedge clk) begin
    hs_e  <= sample_valid && sample_ready && rstn;
    hs_d  <= sample_data;
    clr_e <= underrun_clr;
    en_e  <= enable;
    rst_e <= !rstn;
  end

  // Reference model: pending slot, current frame words, sticky underrun.
  logic [DW-1:0] m_pend;
  bit            m_full;
  logic [DW-1:0] m_act = '0;
  bit            m_ur;
  logic [DW-1:0] exp_q[$];

  // Receiver state.
  bit            coll, sclk_q;
  int            nrise, bad_lr, bad_pad, since_en, last_rise, last_tick;
  logic [DW-1:0] rx, expf;

  always @(negedge clk) begin
    if (rst_e) begin
      chk("reset_outs", {sclk, lrclk, sd, frame_tick, underrun, sample_ready}, '0);
      m_full = 0; m_act = '0; m_ur = 0; exp_q.delete();
      coll = 0; since_en = 0; last_rise = -1; last_tick = -1; sclk_q = 0;
    end else begin
      if (clr_e) m_ur = 0;
      if (frame_tick) begin
        if (m_full) begin
          m_act  = m_pend;
          m_full = 0;
        end else begin
          m_ur = 1;
`ifndef UNDERRUN_HOLD_EN
          m_act = '0;
`endif
        end
        exp_q.push_back(m_act);
      end
      if (hs_e) begin
        m_pend = hs_d;
        m_full = 1;
      end
      chk("ready", sample_ready, !m_full);
      chk("underrun", underrun, m_ur);

      if (!en_e) begin
        chk("idle_outs", {sclk, lrclk, sd, frame_tick}, '0);
        coll = 0; exp_q.delete(); since_en = 0; last_rise = -1; last_tick = -1;
      end else begin
        since_en++;
        if (frame_tick) begin
          if (last_tick < 0) chk("first_tick_lat", since_en, 2 * BCLK_DIV);
          else chk("frame_period", since_en - last_tick, FRAME_CLK);
          last_tick = since_en;
          if (coll) chk("frame_len", nrise, 2 * SLOT_BITS);
          coll = 1; nrise = 0; rx = '0; bad_lr = 0; bad_pad = 0;
        end
        if (sclk && !sclk_q) begin
          if (last_rise >= 0) chk("sclk_period", since_en - last_rise, 2 * BCLK_DIV);
          last_rise = since_en;
          if (coll) begin
            int pos, ch, j;
            nrise++;
            pos = nrise - 1;
            ch  = pos / SLOT_BITS;
            j   = pos % SLOT_BITS;
            if (lrclk !== ((nrise >= SLOT_BITS) && (nrise < 2 * SLOT_BITS))) bad_lr++;
            for (int l = 0; l < N_LINES; l++) begin
              if (j < WIDTH) rx[(2 * l + ch) * WIDTH + WIDTH - 1 - j] = sd[l];
              else if (sd[l] !== 1'b0) bad_pad++;
            end
            if (nrise == 2 * SLOT_BITS) begin
              if (exp_q.size() == 0) begin
                chk("frame_expected", 0, 1);
              end else begin
                expf = exp_q.pop_front();
                chk("frame_data", rx, expf);
              end
              chk("lrclk_pattern", bad_lr, 0);
              chk("slot_padding", bad_pad, 0);
              coll = 0;
            end
          end
        end
      end
      sclk_q = sclk;
    end
  end

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    sample_data  = d;
    sample_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!hs_e && n < 3 * FRAME_CLK);
    if (!hs_e) chk("push_timeout", 0, 1);
    sample_valid = 1'b0;
  endtask

  task automatic rand_push();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 24; w++) d[w * 24 +: 24] = 24'($urandom);
    push(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_data = '0; underrun_clr = 1'b0;
    idle(4);
    rstn = 1'b1;
    idle(2);
    push({24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800001});
    enable = 1'b1;
    push({24'h000000, 24'hFFFFFF, 24'h555555, 24'hAAAAAA});
    idle(3 * FRAME_CLK);
    underrun_clr = 1'b1;
    idle(1);
    underrun_clr = 1'b0;
    idle(FRAME_CLK / 2);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 5))
        0: idle($urandom_range(1, FRAME_CLK));
        1: begin underrun_clr = 1'b1; idle($urandom_range(1, 3)); underrun_clr = 1'b0; end
        default: rand_push();
      endcase
      if (it == 8) begin
        enable = 1'b0;
        idle($urandom_range(3, 40));
        enable = 1'b1;
      end
      if (it == 16) begin
        int n = 0;
        rand_push();
        while (!frame_tick && n < 2 * FRAME_CLK) begin idle(1); n++; end
        if (!frame_tick) chk("tick_timeout", 0, 1);
        // Land inside the left slot, around bit 10.
        idle(10 * 2 * BCLK_DIV - BCLK_DIV);
        rand_push();
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(1);
      end
    end
    rand_push();
    idle(3 * FRAME_CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
